pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: STAGES-deep payload pipeline with per-stage stall and flush.
// Optional macro PIPE_BUBBLE_COLLAPSE_EN lets empty stages squeeze out bubbles under backpressure.
module pipe_ctrl #(
   parameter int STAGES = 5,
   parameter int WIDTH  = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          in_valid_i,
   input  logic [WIDTH-1:0]              in_data_i,
   output logic                          in_ready_o,
   input  logic [STAGES-1:0]             stall_req_i,
   input  logic [STAGES-1:0]             flush_i,
   output logic                          out_valid_o,
   output logic [WIDTH-1:0]              out_data_o,
   input  logic                          out_ready_i,
   output logic [STAGES-1:0]             stage_valid_o,
   output logic [STAGES*WIDTH-1:0]       stage_data_o,
   output logic [STAGES-1:0]             stage_hold_o,
   output logic [$clog2(STAGES+1)-1:0]   count_o,
   output logic [15:0]                   kill_cnt_o
);
   localparam int CW = $clog2(STAGES+1);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] occ, hold, kill;
   logic [CW-1:0]     count_q, count_d, killed;
   logic [15:0]       kill_cnt_q, kill_cnt_d;
   logic [16:0]       kill_sum;

`ifdef PIPE_BUBBLE_COLLAPSE_EN
   assign occ = valid_q;
`else
   assign occ = '1;
`endif

   // hold ripples from the exit toward the entry; kill spreads from a flush point down to stage 0
   always_comb begin
      hold = '0;
      kill = '0;
      hold[STAGES-1] = stall_req_i[STAGES-1] | (occ[STAGES-1] & ~out_ready_i);
      kill[STAGES-1] = flush_i[STAGES-1];
      for (int k = STAGES-2; k >= 0; k--) begin
         hold[k] = stall_req_i[k] | (occ[k] & hold[k+1]);
         kill[k] = flush_i[k] | kill[k+1];
      end
   end

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic             src_valid;
         logic [WIDTH-1:0] src_data;
         logic             v_d;
         logic [WIDTH-1:0] d_d;

         if (gi == 0) begin : g_entry
            assign src_valid = in_valid_i;
            assign src_data  = in_data_i;
         end else begin : g_body
            assign src_valid = valid_q[gi-1] & ~hold[gi-1] & ~kill[gi-1];
            assign src_data  = data_q[gi-1];
         end

         // an advancing stage whose source does not move takes a bubble and keeps its old data
         always_comb begin
            v_d = valid_q[gi];
            d_d = data_q[gi];
            if (kill[gi]) begin
               v_d = 1'b0;
            end else if (!hold[gi]) begin
               v_d = src_valid;
               if (src_valid) begin
                  d_d = src_data;
               end
            end
         end

         assign valid_d[gi] = v_d;
         assign data_d[gi]  = d_d;
         assign stage_data_o[gi*WIDTH +: WIDTH] = data_q[gi];
      end
   endgenerate

   always_comb begin
      count_d = '0;
      killed  = '0;
      for (int k = 0; k < STAGES; k++) begin
         count_d = count_d + CW'(valid_d[k]);
         killed  = killed + CW'(valid_q[k] & kill[k]);
      end
      kill_sum   = {1'b0, kill_cnt_q} + 17'(killed);
      kill_cnt_d = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q    <= '0;
         count_q    <= '0;
         kill_cnt_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         count_q    <= count_d;
         kill_cnt_q <= kill_cnt_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_ready_o    = rst_i & ~hold[0] & ~kill[0];
   assign out_valid_o   = valid_q[STAGES-1];
   assign out_data_o    = data_q[STAGES-1];
   assign stage_valid_o = valid_q;
   assign stage_hold_o  = hold;
   assign count_o       = count_q;
   assign kill_cnt_o    = kill_cnt_q;

endmodule
